// File: rtl/fa_seq_addsub_pkg.sv
// Shared types and sizing helpers for the sequential adder/subtractor.
// Provides the controller state encoding and the slice-count / slice-index
// width calculations used by fa_seq_addsub.
package fa_seq_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int N_DEF      = 16;
  localparam int K_DEF      = 4;
  localparam int NSLICE_DEF = N_DEF / K_DEF;

  // Number of K-bit slices that make up an N-bit operand.
  function automatic int nslice(input int n, input int k);
    return n / k;
  endfunction

  // Slice-index register width; at least one bit even for a single slice.
  function automatic int idx_w(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

// File: rtl/fa_seq_addsub_slice.sv
// fa_slice: K-bit combinational slice adder.
// Ports:
//   a, b      slice operands
//   ci        carry into bit 0 of the slice
//   s         slice sum
//   co        carry out of the top bit
//   c_msb_in  carry into the top bit (used for signed overflow)
module fa_slice #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         ci,
  output logic [K-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [K:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{K{1'b0}}, ci};
  assign s   = sum[K-1:0];
  assign co  = sum[K];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out of
  // the sum without a second, shorter adder (also valid for K=1).
  assign c_msb_in = sum[K-1] ^ a[K-1] ^ b[K-1];

endmodule

// File: rtl/fa_seq_addsub.sv
// fa_seq_addsub: multi-cycle N-bit adder/subtractor, K bits per clock.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   start            request an operation (taken in IDLE or DONE only)
//   A, B, Cin, sub   operands, carry/borrow-in and mode, latched on accept
//   busy             high while slices are being computed
//   done             one-cycle pulse when S/Cout/ovf become valid
//   S, Cout, ovf     result, carry out (sub: 1 = no borrow), signed overflow
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | adding slice idx_q, LSB slice first
// DONE    | result valid for one cycle; start here chains the next op
module fa_seq_addsub
  import fa_seq_addsub_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         ovf
);

  localparam int NSLICE = nslice(N, K);
  localparam int IW     = idx_w(NSLICE);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   s_q, s_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [K-1:0]   a_sl;
  logic [K-1:0]   b_sl;
  logic [K-1:0]   s_sl;
  logic           co_sl;
  logic           cmsb_sl;
  logic           last_slice;

  // Operand mux: select slice idx_q of the latched operands.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int j = 0; j < NSLICE; j++) begin
      if (idx_q == IW'(j)) begin
        a_sl = a_q[j*K +: K];
        b_sl = b_q[j*K +: K];
      end
    end
  end

  fa_slice #(.K(K)) u_slice (
    .a        (a_sl),
    .b        (b_sl),
    .ci       (carry_q),
    .s        (s_sl),
    .co       (co_sl),
    .c_msb_in (cmsb_sl)
  );

  assign last_slice = (idx_q == IW'(NSLICE - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtract is A + ~B + ~Cin: invert once here so RUN only adds.
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? ~Cin : Cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        for (int j = 0; j < NSLICE; j++) begin
          if (idx_q == IW'(j)) begin
            s_d[j*K +: K] = s_sl;
          end
        end
        carry_d = co_sl;
        idx_d   = idx_q + 1'b1;
        if (last_slice) begin
          cout_d  = co_sl;
          ovf_d   = cmsb_sl ^ co_sl;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_fa_seq_addsub.sv
module tb_fa_seq_addsub;

  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      a_in, b_in;
  logic              cin_in, sub_in;
  logic [2:0]        start_v;
  logic [2:0]        busy_v, done_v, cout_v, ovf_v;
  logic [2:0][N-1:0] s_v;

  int   n_cmp = 0;
  int   n_err = 0;
  int   dcnt [3];
  exp_t q0[$], q1[$], q2[$];

  // Instance 0: K=4 (4 slices), 1: K=16 (1 slice), 2: K=1 (16 slices)
  fa_seq_addsub #(.N(N), .K(4)) dut_k4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_in), .B(b_in),
    .Cin(cin_in), .sub(sub_in), .busy(busy_v[0]), .done(done_v[0]),
    .S(s_v[0]), .Cout(cout_v[0]), .ovf(ovf_v[0]));

  fa_seq_addsub #(.N(N), .K(16)) dut_k16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_in), .B(b_in),
    .Cin(cin_in), .sub(sub_in), .busy(busy_v[1]), .done(done_v[1]),
    .S(s_v[1]), .Cout(cout_v[1]), .ovf(ovf_v[1]));

  fa_seq_addsub #(.N(N), .K(1)) dut_k1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_in), .B(b_in),
    .Cin(cin_in), .sub(sub_in), .busy(busy_v[2]), .done(done_v[2]),
    .S(s_v[2]), .Cout(cout_v[2]), .ovf(ovf_v[2]));

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic ci, input logic sb);
    logic [N-1:0] bop;
    logic         c0;
    logic [N:0]   sum;
    exp_t         e;
    bop    = sb ? ~b : b;
    c0     = sb ? ~ci : ci;
    sum    = {1'b0, a} + {1'b0, bop} + {{N{1'b0}}, c0};
    e.s    = sum[N-1:0];
    e.cout = sum[N];
    e.ovf  = (a[N-1] == bop[N-1]) && (sum[N-1] != a[N-1]);
    return e;
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_res(input int d, input exp_t e);
    chk($sformatf("S_dut%0d", d),    32'(s_v[d]),    32'(e.s));
    chk($sformatf("Cout_dut%0d", d), 32'(cout_v[d]), 32'(e.cout));
    chk($sformatf("ovf_dut%0d", d),  32'(ovf_v[d]),  32'(e.ovf));
  endtask

  always @(negedge clk) if (!rst && done_v[0]) begin
    dcnt[0]++;
    if (q0.size() == 0) chk("unexpected_done_dut0", 32'(q0.size()), 32'd1);
    else check_res(0, q0.pop_front());
  end
  always @(negedge clk) if (!rst && done_v[1]) begin
    dcnt[1]++;
    if (q1.size() == 0) chk("unexpected_done_dut1", 32'(q1.size()), 32'd1);
    else check_res(1, q1.pop_front());
  end
  always @(negedge clk) if (!rst && done_v[2]) begin
    dcnt[2]++;
    if (q2.size() == 0) chk("unexpected_done_dut2", 32'(q2.size()), 32'd1);
    else check_res(2, q2.pop_front());
  end

  // Called at a negedge. Returns at the negedge where done is seen.
  task automatic do_op(input int d, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input logic sb, input int ns);
    int lat, bc;
    a_in = a; b_in = b; cin_in = ci; sub_in = sb;
    start_v[d] = 1'b1;
    push_exp(d, model(a, b, ci, sb));
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    lat = 1;
    bc  = 0;
    while (!done_v[d] && lat < 200) begin
      if (busy_v[d]) bc++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency_dut%0d", d), 32'(lat), 32'(ns + 1));
    chk($sformatf("busy_cycles_dut%0d", d), 32'(bc), 32'(ns));
  endtask

  task automatic wait_done(input int d, input string tag);
    int n;
    n = 0;
    while (!done_v[d] && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done_v[d]), 32'd1);
  endtask

  initial begin
    int base;
    dcnt    = '{0, 0, 0};
    start_v = '0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_S",    32'(s_v[0]),    32'd0);
    chk("rst_Cout", 32'(cout_v[0]), 32'd0);
    chk("rst_ovf",  32'(ovf_v[0]),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases on K=4
    do_op(0, 16'h1234, 16'h0FED, 1'b0, 1'b0, 4);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4);
    do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 4);
    do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 4);
    do_op(0, 16'h1234, 16'h1111, 1'b1, 1'b1, 4);
    do_op(0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 4);

    // Back-to-back: start taken in the done cycle, no IDLE gap
    do_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 4);
    chk("b2b_busy_in_done_cycle", 32'(busy_v[0]), 32'd0);
    do_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 4);

    // start during RUN is ignored
    @(negedge clk);
    @(negedge clk);
    a_in = 16'h1000; b_in = 16'h0234; cin_in = 1'b0; sub_in = 1'b0;
    start_v[0] = 1'b1;
    push_exp(0, model(16'h1000, 16'h0234, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b1; sub_in = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, "ignore_done_seen");
    @(posedge clk);
    @(negedge clk);
    chk("ignore_no_requeue_done", 32'(done_v[0]), 32'd0);
    chk("ignore_no_requeue_busy", 32'(busy_v[0]), 32'd0);

    // Asynchronous reset in the third RUN cycle
    a_in = 16'h1111; b_in = 16'h1111; cin_in = 1'b0; sub_in = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_v[0]), 32'd0);
    chk("arst_done", 32'(done_v[0]), 32'd0);
    chk("arst_S",    32'(s_v[0]),    32'd0);
    chk("arst_Cout", 32'(cout_v[0]), 32'd0);
    chk("arst_ovf",  32'(ovf_v[0]),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 4);
    @(negedge clk);

    // K=16: single RUN cycle
    do_op(1, 16'h1234, 16'h0FED, 1'b0, 1'b0, 1);
    do_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1);
    for (int i = 0; i < 20; i++)
      do_op(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1);
    @(negedge clk);
    @(negedge clk);

    // K=16 with start held high: one result every 2 cycles
    base = dcnt[1];
    a_in = 16'h00FF; b_in = 16'h0F01; cin_in = 1'b1; sub_in = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(1, model(16'h00FF, 16'h0F01, 1'b1, 1'b0));
    start_v[1] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_start_results", 32'(dcnt[1] - base), 32'd3);

    // K=1: sixteen RUN cycles
    do_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16);
    do_op(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16);
    for (int i = 0; i < 20; i++)
      do_op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16);

    repeat (4) @(negedge clk);
    chk("pending_dut0", 32'(q0.size()), 32'd0);
    chk("pending_dut1", 32'(q1.size()), 32'd0);
    chk("pending_dut2", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fa_seq_addsub.md
Name: fa_seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It is the sequential successor to the team's combinational N-bit full adder.
- Processes N-bit operands in K-bit slices, one slice per clock, LSB slice first, with a rippled carry register.
- Supports add and subtract (borrow-in) modes and reports carry-out and signed overflow.
- Uses a start/busy/done handshake. It sits in datapaths where a wide adder would break timing and throughput of one result per N/K+1 cycles is enough.

Parameters:
N, 16, operand/result width in bits; must be a multiple of K and at least 1.
K, 4, slice width added per cycle; 1 <= K <= N.

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a new operation; sampled only in IDLE or DONE
A  in  N  first operand; captured on the accepted start edge
B  in  N  second operand; captured on the accepted start edge
Cin  in  1  carry-in (add) or borrow-in (sub); captured on the accepted start edge
sub  in  1  0 = add, 1 = subtract; captured on the accepted start edge
busy  out  1  high while a slice computation is in progress (RUN)
done  out  1  one-cycle pulse; S/Cout/ovf valid from this cycle
S  out  N  result
Cout  out  1  carry out of bit N-1; in sub mode, 1 = no borrow
ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (asynchronous, any time, including mid-RUN):
  - state goes to IDLE.
  - busy=0, done=0, S=0, Cout=0, ovf=0.
  - Operand, carry and slice-counter registers are cleared.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the last slice.
  - DONE -> RUN if start=1, else DONE -> IDLE.
- Accept: on an edge in IDLE or DONE with start=1:
  - latch A;
  - latch Bop = sub ? ~B : B;
  - carry = sub ? ~Cin : Cin;
  - slice index i=0.
- Arithmetic:
  - add: S = A + B + Cin.
  - sub: S = A - B - Cin, implemented as A + ~B + ~Cin.
  - All results are modulo 2^N; Cout is bit N of the (N+1)-bit sum.
- RUN: each edge computes slice i:
  - {c, S[iK+K-1:iK]} = A_slice + Bop_slice + carry;
  - carry <= c, i <= i+1.
  - After slice N/K-1, store Cout = c and ovf = carry-into-MSB XOR carry-out-of-MSB, both from the final slice; then go to DONE.
- Latency:
  - An accepted start at edge t gives busy=1 from t until edge t+N/K.
  - done=1 for exactly the cycle after edge t+N/K.
  - With N=16, K=4: 4 busy cycles, then done.
- Outputs:
  - S/Cout/ovf hold their final values from done until the next accepted start.
  - S is undefined (partial) while busy; the bench must not check it then.
- Boundary conditions:
  - start during RUN is ignored; no queueing, and A/B/Cin/sub changes have no effect.
  - start in the DONE cycle is accepted: back-to-back operation with no IDLE gap, and done drops in the next cycle.
  - K=N: one RUN cycle, so done appears 2 edges after start.
  - K=1: N RUN cycles.
  - start held high continuously: one operation every N/K+1 cycles.

Decomposition:
- Shared package: state typedef (IDLE/RUN/DONE) and a localparam NSLICE = N/K, with slice-index width $clog2(NSLICE) (min 1).
- One sub-module, fa_slice:
  - K-bit combinational slice adder with inputs a, b, ci and outputs s, co, c_msb_in (carry into the top bit, used for ovf).
  - Instanced once and reused each cycle through operand muxing by slice index.

Test Plan:
- N=16, K=4, add: A=0x1234, B=0x0FED, Cin=0 -> after 4 busy cycles done=1, S=0x2221, Cout=0, ovf=0.
- Add: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, ovf=0. Then A=0x7FFF, B=0x0001 -> S=0x8000, Cout=0, ovf=1.
- Sub: A=0x0005, B=0x0007, Cin=0 -> S=0xFFFE, Cout=0 (borrow), ovf=0. Then A=0x8000, B=0x0001 -> S=0x7FFF, Cout=1, ovf=1.
- Handshake:
  - start pulsed again in the 2nd busy cycle with different operands -> ignored, first result unchanged.
  - start asserted in the done cycle with A=1, B=2 -> next done gives S=0x0003 with no IDLE cycle between.
- Reset: assert rst in the 3rd RUN cycle -> busy, done, S, Cout and ovf are 0 immediately (asynchronously). After release, a fresh start A=0x0001, B=0x0001 -> S=0x0002.
- Parameter sweep:
  - K=16: done 2 edges after start.
  - K=1: done after 16 busy cycles.
  - Random A/B/Cin/sub compared against an (N+1)-bit reference sum for both settings.
